// File: rtl/reg_snapshot_dumper.sv
// reg_snapshot_dumper
//   Captures registers r0..r(NUM_REGS-1) through a dedicated register-file
//   read port and then streams the snapshot out over a valid/ready
//   interface. A dump starts on start_i or once per reset when the cycle
//   counter reaches TRIGGER_CYCLE. freeze_o stalls the CPU while the
//   registers are being read so the snapshot is coherent.
//
//   Optional build macro: DUMP_CHECKSUM_EN
//     When defined, one extra beat follows the register beats. That beat
//     has idx = NUM_REGS and carries the XOR of all captured words.
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous reset, active-low
//   start_i       manual dump request (level, sampled at the rising edge)
//   rf_addr_o     register-file read address
//   rf_data_i     register-file read data (combinational from rf_addr_o)
//   freeze_o      CPU stall request, high while capturing
//   dump_valid_o  stream beat valid
//   dump_ready_i  stream sink ready
//   dump_data_o   beat payload
//   dump_idx_o    register index of the beat
//   dump_last_o   final beat of the dump
//   busy_o        dump in progress (capture, send or done)
//   done_o        one-cycle pulse after the final beat is accepted
//   cycle_cnt_o   saturating count of cycles since reset release
module reg_snapshot_dumper #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int NUM_REGS      = 13,
    parameter int TRIGGER_CYCLE = 25,
    parameter int CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              freeze_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    // One extra index bit so the checksum beat index (NUM_REGS) is
    // representable even when NUM_REGS == 2**ADDR_W.
    localparam int IDX_W = ADDR_W + 1;
`ifdef DUMP_CHECKSUM_EN
    localparam int LAST_BEAT = NUM_REGS;
`else
    localparam int LAST_BEAT = NUM_REGS - 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               auto_fired;
    logic               auto_hit;
    logic               trig;
    logic [ADDR_W-1:0]  addr;
    logic [IDX_W-1:0]   beat;
    logic [DATA_W-1:0]  snap [NUM_REGS];
    logic [DATA_W-1:0]  beat_word;
    logic               cap_end;
    logic               beat_end;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]  csum;
`endif

    assign auto_hit = (TRIGGER_CYCLE != 0) && (cnt == CNT_W'(TRIGGER_CYCLE)) && !auto_fired;
    assign trig     = start_i || auto_hit;
    assign cap_end  = (addr == ADDR_W'(NUM_REGS - 1));
    assign beat_end = (beat == IDX_W'(LAST_BEAT));

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trig) state_next = CAPTURE;
            CAPTURE: if (cap_end) state_next = SEND;
            SEND:    if (dump_ready_i && beat_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- cycle counter and auto-trigger latch ----------------
    // auto_fired is set whenever the auto condition hits, even while busy,
    // so an auto trigger landing mid-dump is consumed and lost.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt        <= '0;
            auto_fired <= 1'b0;
        end else begin
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (auto_hit) begin
                auto_fired <= 1'b1;
            end
        end
    end

    // ---------------- capture / send datapath ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr <= '0;
            beat <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                snap[i] <= '0;
            end
`ifdef DUMP_CHECKSUM_EN
            csum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    addr <= '0;
                    beat <= '0;
`ifdef DUMP_CHECKSUM_EN
                    csum <= '0;
`endif
                end
                CAPTURE: begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (addr == ADDR_W'(i)) begin
                            snap[i] <= rf_data_i;
                        end
                    end
`ifdef DUMP_CHECKSUM_EN
                    csum <= csum ^ rf_data_i;
`endif
                    addr <= cap_end ? '0 : addr + ADDR_W'(1);
                end
                SEND: begin
                    if (dump_ready_i) begin
                        beat <= beat_end ? '0 : beat + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat payload is a mux over the snapshot; it only changes when beat
    // advances, which keeps the payload stable under backpressure.
    always_comb begin
        beat_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (beat == IDX_W'(i)) begin
                beat_word = snap[i];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        if (beat == IDX_W'(NUM_REGS)) begin
            beat_word = csum;
        end
`endif
    end

    // ---------------- outputs ----------------
    assign rf_addr_o    = addr;
    assign freeze_o     = (state == CAPTURE);
    assign dump_valid_o = (state == SEND);
    assign dump_data_o  = dump_valid_o ? beat_word : '0;
    assign dump_idx_o   = dump_valid_o ? beat[ADDR_W-1:0] : '0;
    assign dump_last_o  = dump_valid_o && beat_end;
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign cycle_cnt_o  = cnt;

endmodule

// File: tb/tb_reg_snapshot_dumper.sv
// tb_reg_snapshot_dumper
//   Randomized bench for reg_snapshot_dumper at default parameters. A
//   transaction-level reference model (capture countdown plus a queue of
//   expected beats) predicts every output each cycle; directed phases add
//   checks of absolute timing, beat counts and reset behaviour.
//   Honours DUMP_CHECKSUM_EN in the same way as the design.
module tb_reg_snapshot_dumper;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 13;
    localparam int TC = 25;
    localparam int CW = 16;
`ifdef DUMP_CHECKSUM_EN
    localparam int NBEATS = NR + 1;
`else
    localparam int NBEATS = NR;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          freeze;
    logic          dump_valid;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_idx;
    logic          dump_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_cnt;

    logic [DW-1:0] rf [32];

    always #5 clk = ~clk;
    assign rf_data = rf[rf_addr];

    reg_snapshot_dumper #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NUM_REGS(NR),
        .TRIGGER_CYCLE(TC),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .start_i(start),
        .rf_addr_o(rf_addr),
        .rf_data_i(rf_data),
        .freeze_o(freeze),
        .dump_valid_o(dump_valid),
        .dump_ready_i(ready),
        .dump_data_o(dump_data),
        .dump_idx_o(dump_idx),
        .dump_last_o(dump_last),
        .busy_o(busy),
        .done_o(done),
        .cycle_cnt_o(cycle_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } beat_t;

    int    m_cnt;
    bit    m_fired;
    int    m_cap;     // capture cycles still to go
    bit    m_done;
    beat_t m_q[$];    // beats still to be delivered

    // observed statistics for directed checks
    int fz_first, fz_last, n_fz_starts, n_done_seen, done_at;
    int n_acc, acc_idx, first_idx;
    bit prev_fz;

    function automatic bit m_busy();
        return (m_cap > 0) || (m_q.size() > 0) || m_done;
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_fired = 0;
        m_cap   = 0;
        m_done  = 0;
        m_q.delete();
    endtask

    task automatic clear_stats();
        fz_first    = -1;
        fz_last     = -1;
        n_fz_starts = 0;
        n_done_seen = 0;
        done_at     = -1;
        n_acc       = 0;
        acc_idx     = -1;
        first_idx   = -1;
        prev_fz     = 0;
    endtask

    task automatic push_snapshot();
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NR; i++) begin
            m_q.push_back('{idx: i, data: rf[i]});
            x ^= rf[i];
        end
`ifdef DUMP_CHECKSUM_EN
        m_q.push_back('{idx: NR, data: x});
`endif
    endtask

    task automatic compare_outputs();
        bit ef;
        bit ev;
        ef = (m_cap > 0);
        ev = (m_cap == 0) && (m_q.size() > 0);
        check("cycle_cnt", cycle_cnt, m_cnt);
        check("freeze", freeze, ef);
        check("valid", dump_valid, ev);
        check("busy", busy, m_busy());
        check("done", done, m_done);
        if (ev) begin
            check("data", dump_data, m_q[0].data);
            check("idx", dump_idx, m_q[0].idx);
            check("last", dump_last, m_q.size() == 1);
        end
        if (freeze && !prev_fz) begin
            n_fz_starts++;
            if (fz_first < 0) fz_first = int'(cycle_cnt);
        end
        if (freeze) fz_last = int'(cycle_cnt);
        prev_fz = freeze;
        if (done) begin
            n_done_seen++;
            done_at = int'(cycle_cnt);
        end
        if (dump_valid && first_idx < 0) first_idx = int'(dump_idx);
    endtask

    // Advances the model across one rising edge using the inputs now applied.
    task automatic model_step();
        bit auto_t;
        bit trig_t;
        auto_t = (TC != 0) && (m_cnt == TC) && !m_fired;
        if (auto_t) m_fired = 1;
        trig_t = start || auto_t;
        if (!m_busy()) begin
            if (trig_t) m_cap = NR;
        end else if (m_cap > 0) begin
            m_cap--;
            if (m_cap == 0) push_snapshot();
        end else if (m_q.size() > 0) begin
            if (ready) begin
                acc_idx = m_q[0].idx;
                n_acc++;
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1;
            end
        end else begin
            m_done = 0;
        end
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    // One clock: compare at the falling edge, then apply inputs for the next
    // rising edge. The register file only changes while the CPU is not frozen.
    task automatic tick(input bit s, input bit r, input bit mutate);
        @(negedge clk);
        compare_outputs();
        start = s;
        ready = r;
        if (mutate && m_cap == 0) begin
            rf[$urandom_range(NR - 1, 0)] = $urandom;
        end
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_freeze", freeze, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_data", dump_data, 0);
        check("rst_idx", dump_idx, 0);
        check("rst_last", dump_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int c0;
        bit pulsed;
        bit hit;

        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = DW'(10 * i);
        model_reset();
        clear_stats();

        // Auto dump at count 25 with ready held high, no manual start
        do_reset();
        clear_stats();
        for (int c = 0; c <= 200; c++) tick(1'b0, 1'b1, 1'b0);
        check("auto_freeze_first", fz_first, 26);
        check("auto_freeze_last", fz_last, 26 + NR - 1);
        check("auto_dumps", n_fz_starts, 1);
        check("auto_done_count", n_done_seen, 1);
        check("auto_done_at", done_at, 26 + NR + NBEATS);
        check("auto_beats", n_acc, NBEATS);
        check("auto_last_idx", acc_idx, NBEATS - 1);

        // Manual start: fixed latency from the sampling edge to done
        clear_stats();
        c0 = m_cnt;
        tick(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 40; c++) tick(1'b0, 1'b1, 1'b0);
        check("man_freeze_first", fz_first, c0 + 1);
        check("man_done_at", done_at, c0 + 1 + NR + NBEATS);
        check("man_dumps", n_fz_starts, 1);

        // Backpressure: ready 1,0,0,1,0,0...
        clear_stats();
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 90; k++) tick(1'b0, (k % 3) == 0, 1'b1);
        check("bp_beats", n_acc, NBEATS);
        check("bp_done_count", n_done_seen, 1);

        // Start pulse while sending is dropped
        clear_stats();
        pulsed = 0;
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 60; k++) begin
            bit s;
            s = !pulsed && (m_cap == 0) && (m_q.size() == 5);
            if (s) pulsed = 1;
            tick(s, 1'b1, 1'b1);
        end
        check("busy_start_dumps", n_fz_starts, 1);
        check("busy_start_done", n_done_seen, 1);
        check("busy_start_idle", busy, 0);

        // Reset right after beat 4 of the auto dump is accepted
        do_reset();
        clear_stats();
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (acc_idx == 4) hit = 1;
        end
        check("beat4_reached", hit, 1);
        do_reset();
        clear_stats();
        for (int k = 0; k < 60; k++) tick(1'b0, 1'($urandom_range(1, 0)), 1'b1);
        check("rearm_freeze_first", fz_first, 26);
        check("rearm_first_idx", first_idx, 0);

        // Random traffic with one mid-run reset
        clear_stats();
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            tick($urandom_range(39, 0) == 0, $urandom_range(3, 0) != 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
